// File: rtl/vrf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vrf_pkg
// Description : Shared types for the vector register file. The typedefs
//               describe the default configuration (128-bit registers,
//               32 entries); parameterised modules derive their defaults
//               from the localparams below.
// Revision    : 1.0 - initial release
// ============================================================================
package vrf_pkg;

    localparam int unsigned VRF_VLEN      = 128;
    localparam int unsigned VRF_REG_NUM   = 32;
    localparam int unsigned VRF_REG_WIDTH = $clog2(VRF_REG_NUM);
    localparam int unsigned VRF_NBYTES    = VRF_VLEN / 8;

    typedef logic [VRF_VLEN-1:0]      vdata_t;
    typedef logic [VRF_NBYTES-1:0]    vbe_t;
    typedef logic [VRF_REG_WIDTH-1:0] vaddr_t;

    // One write port worth of request signals.
    typedef struct packed {
        logic   en;
        vaddr_t addr;
        vdata_t data;
        vbe_t   be;
        logic   last;
    } vwport_t;

endpackage : vrf_pkg
`default_nettype wire

// File: rtl/vrf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : vrf_scoreboard
// Description : Busy-bit scoreboard for the vector register file. An issue
//               sets the destination's bit, a final write clears it; when
//               both hit the same register in one cycle the set wins.
// Ports       : clk_i, rst_ni       - clock, async active-low reset
//               set_valid_i/addr_i  - issue request (mark busy)
//               clr_valid_i/addr_i  - per write port clear request
//               busy_o              - scoreboard vector
// Revision    : 1.0 - initial release
// ============================================================================
module vrf_scoreboard
    import vrf_pkg::*;
#(
    parameter int unsigned RegNum       = VRF_REG_NUM,
    parameter int unsigned RegWidth     = $clog2(RegNum),
    parameter int unsigned NumWritePort = 2,
    parameter bit          ZeroReg      = 1'b0
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   set_valid_i,
    input  logic [RegWidth-1:0]                    set_addr_i,
    input  logic [NumWritePort-1:0]                clr_valid_i,
    input  logic [NumWritePort-1:0][RegWidth-1:0]  clr_addr_i,
    output logic [RegNum-1:0]                      busy_o
);

    logic [RegNum-1:0] r_busy;
    logic [RegNum-1:0] w_set;
    logic [RegNum-1:0] w_clr;
    logic [RegNum-1:0] w_busy_nxt;

    always_comb begin
        w_set = '0;
        w_clr = '0;
        for (int r = 0; r < RegNum; r++) begin
            if (set_valid_i && (set_addr_i == RegWidth'(r))) begin
                w_set[r] = 1'b1;
            end
            for (int p = 0; p < NumWritePort; p++) begin
                if (clr_valid_i[p] && (clr_addr_i[p] == RegWidth'(r))) begin
                    w_clr[r] = 1'b1;
                end
            end
        end
        // OR-ing the set after masking the clear gives the set priority.
        w_busy_nxt = (r_busy & ~w_clr) | w_set;
        if (ZeroReg) begin
            w_busy_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign busy_o = r_busy;

endmodule : vrf_scoreboard
`default_nettype wire

// File: rtl/vregfile.sv
`default_nettype none
// ============================================================================
// Module      : vregfile
// Description : Multi-ported vector register file with byte-enable writes,
//               optional same-cycle write-to-read forwarding, optional
//               hardwired-zero register 0 and a busy scoreboard.
// Ports       : clk_i, rst_ni                 - clock, async active-low reset
//               reg_raddr_i/rdata_o/rbusy_o   - combinational read ports
//               reg_wen_i/waddr_i/wdata_i/
//               reg_wbe_i/wlast_i             - byte-masked write ports
//               iss_valid_i/iss_addr_i        - issue (mark destination busy)
//               busy_o                        - full scoreboard vector
// Revision    : 1.0 - initial release
// ============================================================================
module vregfile
    import vrf_pkg::*;
#(
    parameter int unsigned VLEN         = VRF_VLEN,
    parameter int unsigned RegNum       = VRF_REG_NUM,
    parameter int unsigned RegWidth     = $clog2(RegNum),
    parameter int unsigned NumReadPort  = 3,
    parameter int unsigned NumWritePort = 2,
    parameter bit          Bypass       = 1'b1,
    parameter bit          ZeroReg      = 1'b0
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NumReadPort-1:0][RegWidth-1:0]   reg_raddr_i,
    output logic [NumReadPort-1:0][VLEN-1:0]       reg_rdata_o,
    output logic [NumReadPort-1:0]                 reg_rbusy_o,
    input  logic [NumWritePort-1:0]                reg_wen_i,
    input  logic [NumWritePort-1:0][RegWidth-1:0]  reg_waddr_i,
    input  logic [NumWritePort-1:0][VLEN-1:0]      reg_wdata_i,
    input  logic [NumWritePort-1:0][VLEN/8-1:0]    reg_wbe_i,
    input  logic [NumWritePort-1:0]                reg_wlast_i,
    input  logic                                   iss_valid_i,
    input  logic [RegWidth-1:0]                    iss_addr_i,
    output logic [RegNum-1:0]                      busy_o
);

    localparam int unsigned C_NBYTES = VLEN / 8;

    // Same shape as vrf_pkg::vwport_t, sized by this instance's parameters.
    typedef struct packed {
        logic                en;
        logic [RegWidth-1:0] addr;
        logic [VLEN-1:0]     data;
        logic [C_NBYTES-1:0] be;
        logic                last;
    } wport_t;

    wport_t [NumWritePort-1:0]               w_wport;
    logic   [NumWritePort-1:0]               w_clr_valid;
    logic   [NumWritePort-1:0][RegWidth-1:0] w_clr_addr;

    logic [VLEN-1:0] r_regs     [RegNum];
    logic [VLEN-1:0] w_regs_nxt [RegNum];

    always_comb begin
        for (int p = 0; p < NumWritePort; p++) begin
            w_wport[p].en   = reg_wen_i[p];
            w_wport[p].addr = reg_waddr_i[p];
            w_wport[p].data = reg_wdata_i[p];
            w_wport[p].be   = reg_wbe_i[p];
            w_wport[p].last = reg_wlast_i[p];
            // A final write releases the register even with an empty byte mask.
            w_clr_valid[p]  = reg_wen_i[p] & reg_wlast_i[p];
            w_clr_addr[p]   = reg_waddr_i[p];
        end
    end

    // Per-register, per-byte merge. Ports are visited in ascending order so
    // the highest-indexed enabled port overwrites any earlier one on a shared
    // byte, while disjoint bytes from different ports all land.
    always_comb begin
        for (int r = 0; r < RegNum; r++) begin
            w_regs_nxt[r] = r_regs[r];
            for (int p = 0; p < NumWritePort; p++) begin
                if (w_wport[p].en && (w_wport[p].addr == RegWidth'(r))) begin
                    for (int b = 0; b < C_NBYTES; b++) begin
                        if (w_wport[p].be[b]) begin
                            w_regs_nxt[r][8*b +: 8] = w_wport[p].data[8*b +: 8];
                        end
                    end
                end
            end
            if (ZeroReg && (r == 0)) begin
                w_regs_nxt[r] = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < RegNum; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            for (int r = 0; r < RegNum; r++) begin
                r_regs[r] <= w_regs_nxt[r];
            end
        end
    end

    // With forwarding the read taps the merged next-state, so the current
    // cycle's writes are already visible; otherwise it taps the array.
    // Addresses beyond the populated range read as zero / not busy.
    always_comb begin
        for (int i = 0; i < NumReadPort; i++) begin
            reg_rdata_o[i] = '0;
            reg_rbusy_o[i] = 1'b0;
            if (32'(reg_raddr_i[i]) < RegNum) begin
                reg_rdata_o[i] = Bypass ? w_regs_nxt[reg_raddr_i[i]]
                                        : r_regs[reg_raddr_i[i]];
                reg_rbusy_o[i] = busy_o[reg_raddr_i[i]];
            end
        end
    end

    vrf_scoreboard #(
        .RegNum       (RegNum),
        .RegWidth     (RegWidth),
        .NumWritePort (NumWritePort),
        .ZeroReg      (ZeroReg)
    ) u_scoreboard (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .set_valid_i (iss_valid_i),
        .set_addr_i  (iss_addr_i),
        .clr_valid_i (w_clr_valid),
        .clr_addr_i  (w_clr_addr),
        .busy_o      (busy_o)
    );

endmodule : vregfile
`default_nettype wire

// File: tb/tb_vregfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_vregfile
// Description : Self-checking bench for vregfile. Three instances share the
//               stimulus: forwarding on, forwarding off, and hardwired-zero
//               register 0. Directed vector table, hand-written reset and
//               zero-register sequences, then random traffic against a
//               byte-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vregfile;

    localparam int unsigned VL = 128;
    localparam int unsigned RN = 32;
    localparam int unsigned RW = 5;
    localparam int unsigned NR = 3;
    localparam int unsigned NW = 2;
    localparam int unsigned NB = VL / 8;

    logic                      clk = 1'b0;
    logic                      rst_ni;
    logic [NR-1:0][RW-1:0]     raddr;
    logic [NR-1:0][VL-1:0]     rdata_a, rdata_nb, rdata_z;
    logic [NR-1:0]             rbusy_a, rbusy_nb, rbusy_z;
    logic [NW-1:0]             wen;
    logic [NW-1:0][RW-1:0]     waddr;
    logic [NW-1:0][VL-1:0]     wdata;
    logic [NW-1:0][NB-1:0]     wbe;
    logic [NW-1:0]             wlast;
    logic                      iss_valid;
    logic [RW-1:0]             iss_addr;
    logic [RN-1:0]             busy_a, busy_nb, busy_z;

    always #5 clk = ~clk;

    vregfile #(.Bypass(1'b1), .ZeroReg(1'b0)) u_dut (
        .clk_i(clk), .rst_ni(rst_ni), .reg_raddr_i(raddr), .reg_rdata_o(rdata_a),
        .reg_rbusy_o(rbusy_a), .reg_wen_i(wen), .reg_waddr_i(waddr), .reg_wdata_i(wdata),
        .reg_wbe_i(wbe), .reg_wlast_i(wlast), .iss_valid_i(iss_valid),
        .iss_addr_i(iss_addr), .busy_o(busy_a));

    vregfile #(.Bypass(1'b0), .ZeroReg(1'b0)) u_dut_nb (
        .clk_i(clk), .rst_ni(rst_ni), .reg_raddr_i(raddr), .reg_rdata_o(rdata_nb),
        .reg_rbusy_o(rbusy_nb), .reg_wen_i(wen), .reg_waddr_i(waddr), .reg_wdata_i(wdata),
        .reg_wbe_i(wbe), .reg_wlast_i(wlast), .iss_valid_i(iss_valid),
        .iss_addr_i(iss_addr), .busy_o(busy_nb));

    vregfile #(.Bypass(1'b1), .ZeroReg(1'b1)) u_dut_z (
        .clk_i(clk), .rst_ni(rst_ni), .reg_raddr_i(raddr), .reg_rdata_o(rdata_z),
        .reg_rbusy_o(rbusy_z), .reg_wen_i(wen), .reg_waddr_i(waddr), .reg_wdata_i(wdata),
        .reg_wbe_i(wbe), .reg_wlast_i(wlast), .iss_valid_i(iss_valid),
        .iss_addr_i(iss_addr), .busy_o(busy_z));

    // ---------------- reference model ----------------
    logic [VL-1:0] m_reg  [RN];
    logic [VL-1:0] m_regz [RN];
    logic [RN-1:0] m_busy;
    logic [RN-1:0] m_busyz;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [VL-1:0] act, input logic [VL-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Register value as seen after applying this cycle's writes: bytes are
    // taken port by port, so a later port's byte replaces an earlier one.
    function automatic logic [VL-1:0] merged(input logic [VL-1:0] cur, input int r, input bit zero);
        logic [7:0] bytes [NB];
        logic [VL-1:0] res;
        if (zero && r == 0) return '0;
        for (int b = 0; b < NB; b++) bytes[b] = cur[8*b +: 8];
        for (int p = 0; p < NW; p++)
            if (wen[p] && int'(waddr[p]) == r)
                for (int b = 0; b < NB; b++)
                    if (wbe[p][b]) bytes[b] = wdata[p][8*b +: 8];
        for (int b = 0; b < NB; b++) res[8*b +: 8] = bytes[b];
        return res;
    endfunction

    function automatic logic [RN-1:0] busy_next(input logic [RN-1:0] cur, input bit zero);
        logic [RN-1:0] res = cur;
        for (int p = 0; p < NW; p++)
            if (wen[p] && wlast[p]) res[waddr[p]] = 1'b0;
        if (iss_valid) res[iss_addr] = 1'b1;
        if (zero) res[0] = 1'b0;
        return res;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < RN; r++) begin
            m_reg[r]  = '0;
            m_regz[r] = '0;
        end
        m_busy  = '0;
        m_busyz = '0;
    endtask

    // Advance one clock and move the model along with it.
    task automatic tick();
        logic [VL-1:0] na [RN];
        logic [VL-1:0] nz [RN];
        logic [RN-1:0] nba, nbz;
        for (int r = 0; r < RN; r++) begin
            na[r] = merged(m_reg[r], r, 1'b0);
            nz[r] = merged(m_regz[r], r, 1'b1);
        end
        nba = busy_next(m_busy, 1'b0);
        nbz = busy_next(m_busyz, 1'b1);
        @(posedge clk);
        #1;
        for (int r = 0; r < RN; r++) begin
            m_reg[r]  = na[r];
            m_regz[r] = nz[r];
        end
        m_busy  = nba;
        m_busyz = nbz;
    endtask

    task automatic idle();
        wen = '0; waddr = '0; wdata = '0; wbe = '0; wlast = '0;
        iss_valid = 1'b0; iss_addr = '0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic [1:0]    wen;
        logic [RW-1:0] wa0, wa1;
        logic [VL-1:0] wd0, wd1;
        logic [NB-1:0] be0, be1;
        logic [1:0]    wlast;
        logic          iss;
        logic [RW-1:0] ia;
        logic [RW-1:0] ra;
        logic [VL-1:0] exp_byp;
        logic [VL-1:0] exp_nb;
        logic          exp_rbusy;
        logic [RW-1:0] ba;
        logic          exp_busy;
    } vec_t;

    function automatic vec_t mk(
        input logic [1:0] w, input int a0, input logic [VL-1:0] d0, input logic [NB-1:0] b0,
        input int a1, input logic [VL-1:0] d1, input logic [NB-1:0] b1, input logic [1:0] l,
        input logic is, input int ia, input int ra, input logic [VL-1:0] eb,
        input logic [VL-1:0] en, input logic erb, input int ba, input logic eb2);
        vec_t v;
        v.wen = w; v.wa0 = RW'(a0); v.wd0 = d0; v.be0 = b0;
        v.wa1 = RW'(a1); v.wd1 = d1; v.be1 = b1; v.wlast = l;
        v.iss = is; v.ia = RW'(ia); v.ra = RW'(ra);
        v.exp_byp = eb; v.exp_nb = en; v.exp_rbusy = erb; v.ba = RW'(ba); v.exp_busy = eb2;
        return v;
    endfunction

    localparam int NV = 17;
    vec_t tbl [NV];

    initial begin
        logic [VL-1:0] ones, aa, x55, mix;
        ones = '1;
        aa   = {16{8'hAA}};
        x55  = {16{8'h55}};
        mix  = 128'h00000000_22222222_11111111_22222222;

        //           wen    a0 d0          be0      a1 d1          be1      last  is ia ra exp_byp         exp_nb          rb ba busy
        tbl[0]  = mk(2'b01, 5, ones,       16'hFFFF, 0, '0,         16'h0,   2'b00, 0, 0, 5, ones,           '0,             0, 5, 0);
        tbl[1]  = mk(2'b01, 5, '0,         16'h0001, 0, '0,         16'h0,   2'b00, 0, 0, 5, {ones[127:8],8'h00}, ones,      0, 5, 0);
        tbl[2]  = mk(2'b00, 0, '0,         16'h0,    0, '0,         16'h0,   2'b00, 0, 0, 5, {ones[127:8],8'h00}, {ones[127:8],8'h00}, 0, 5, 0);
        tbl[3]  = mk(2'b11, 3, aa,         16'hFFFF, 3, x55,        16'hFFFF, 2'b00, 0, 0, 3, x55,           '0,             0, 3, 0);
        tbl[4]  = mk(2'b00, 0, '0,         16'h0,    0, '0,         16'h0,   2'b00, 0, 0, 3, x55,            x55,            0, 3, 0);
        tbl[5]  = mk(2'b01, 7, 128'h1234,  16'hFFFF, 0, '0,         16'h0,   2'b00, 0, 0, 7, 128'h1234,      '0,             0, 7, 0);
        tbl[6]  = mk(2'b00, 0, '0,         16'h0,    0, '0,         16'h0,   2'b00, 0, 0, 7, 128'h1234,      128'h1234,      0, 7, 0);
        tbl[7]  = mk(2'b00, 0, '0,         16'h0,    0, '0,         16'h0,   2'b00, 1, 9, 9, '0,             '0,             0, 9, 1);
        tbl[8]  = mk(2'b01, 9, 128'hBEEF,  16'hFFFF, 0, '0,         16'h0,   2'b00, 0, 0, 9, 128'hBEEF,      '0,             1, 9, 1);
        tbl[9]  = mk(2'b01, 9, 128'hCAFE,  16'h0001, 0, '0,         16'h0,   2'b01, 0, 0, 9, 128'hBEFE,      128'hBEEF,      1, 9, 0);
        tbl[10] = mk(2'b00, 0, '0,         16'h0,    0, '0,         16'h0,   2'b00, 1, 10, 10, '0,           '0,             0, 10, 1);
        tbl[11] = mk(2'b01, 10, ones,      16'h0000, 0, '0,         16'h0,   2'b01, 0, 0, 10, '0,            '0,             1, 10, 0);
        tbl[12] = mk(2'b01, 4, 128'h44,    16'hFFFF, 0, '0,         16'h0,   2'b01, 1, 4, 4, 128'h44,        '0,             0, 4, 1);
        tbl[13] = mk(2'b00, 0, '0,         16'h0,    0, '0,         16'h0,   2'b00, 1, 4, 4, 128'h44,        128'h44,        1, 4, 1);
        tbl[14] = mk(2'b10, 0, '0,         16'h0,    4, 128'h77,    16'hFFFF, 2'b10, 0, 0, 4, 128'h77,       128'h44,        1, 4, 0);
        tbl[15] = mk(2'b11, 6, {16{8'h11}}, 16'h00FF, 6, {16{8'h22}}, 16'h0F0F, 2'b00, 0, 0, 6, mix,        '0,             0, 6, 0);
        tbl[16] = mk(2'b00, 0, '0,         16'h0,    0, '0,         16'h0,   2'b00, 0, 0, 6, mix,            mix,            0, 6, 0);
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_ni = 1'b0;
        idle();
        raddr = '0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        raddr[0] = 5'd5; raddr[1] = 5'd17; raddr[2] = 5'd31;
        #1;
        chk("reset_busy", VL'(busy_a), '0);
        chk("reset_busy_z", VL'(busy_z), '0);
        chk("reset_rdata1", rdata_a[1], '0);
        chk("reset_rdata2_nb", rdata_nb[2], '0);
        rst_ni = 1'b1;
        @(posedge clk); #1;

        // directed table
        for (int i = 0; i < NV; i++) begin
            wen = tbl[i].wen;
            waddr[0] = tbl[i].wa0; waddr[1] = tbl[i].wa1;
            wdata[0] = tbl[i].wd0; wdata[1] = tbl[i].wd1;
            wbe[0] = tbl[i].be0; wbe[1] = tbl[i].be1;
            wlast = tbl[i].wlast;
            iss_valid = tbl[i].iss; iss_addr = tbl[i].ia;
            raddr[0] = tbl[i].ra; raddr[1] = '0; raddr[2] = '0;
            @(negedge clk);
            chk($sformatf("vec%0d_rdata_byp", i), rdata_a[0], tbl[i].exp_byp);
            chk($sformatf("vec%0d_rdata_nobyp", i), rdata_nb[0], tbl[i].exp_nb);
            chk($sformatf("vec%0d_rbusy", i), VL'(rbusy_a[0]), VL'(tbl[i].exp_rbusy));
            tick();
            chk($sformatf("vec%0d_busy_after", i), VL'(busy_a[tbl[i].ba]), VL'(tbl[i].exp_busy));
        end
        idle();

        // reset in the middle of operation
        wen = 2'b01; waddr[0] = 5'd2; wdata[0] = 128'h2222; wbe[0] = '1;
        iss_valid = 1'b1; iss_addr = 5'd2; raddr[0] = 5'd2;
        tick();
        idle();
        @(negedge clk);
        chk("pre_rst_busy2", VL'(busy_a[2]), VL'(1'b1));
        chk("pre_rst_v2", rdata_nb[0], 128'h2222);
        wen = 2'b01; waddr[0] = 5'd2; wdata[0] = 128'hFFFF; wbe[0] = '1;
        rst_ni = 1'b0;
        #1;
        chk("in_rst_v2_nb", rdata_nb[0], '0);
        chk("in_rst_busy", VL'(busy_a), '0);
        @(posedge clk); #1;
        model_clear();
        idle();
        @(negedge clk);
        rst_ni = 1'b1;
        #1;
        chk("post_rst_v2", rdata_a[0], '0);
        chk("post_rst_v2_nb", rdata_nb[0], '0);
        chk("post_rst_busy", VL'(busy_nb), '0);
        @(posedge clk); #1;

        // hardwired zero register
        wen = 2'b01; waddr[0] = 5'd0; wdata[0] = 128'hDEAD; wbe[0] = '1;
        iss_valid = 1'b1; iss_addr = 5'd0; raddr[0] = 5'd0;
        @(negedge clk);
        chk("zreg_byp_z", rdata_z[0], '0);
        chk("zreg_byp_a", rdata_a[0], 128'hDEAD);
        tick();
        idle();
        @(negedge clk);
        chk("zreg_read_z", rdata_z[0], '0);
        chk("zreg_busy_z", VL'(busy_z[0]), '0);
        chk("zreg_busy_a", VL'(busy_a[0]), VL'(1'b1));
        chk("zreg_read_a", rdata_a[0], 128'hDEAD);
        @(posedge clk); #1;

        // random traffic against the model
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < NW; p++) begin
                wen[p]   = ($urandom_range(0, 2) != 0);
                waddr[p] = RW'($urandom_range(0, 7));
                wdata[p] = {$urandom, $urandom, $urandom, $urandom};
                case ($urandom_range(0, 3))
                    0:       wbe[p] = '1;
                    1:       wbe[p] = '0;
                    default: wbe[p] = NB'($urandom);
                endcase
                wlast[p] = ($urandom_range(0, 1) == 1);
            end
            iss_valid = ($urandom_range(0, 1) == 1);
            iss_addr  = RW'($urandom_range(0, 7));
            for (int i = 0; i < NR; i++) raddr[i] = RW'($urandom_range(0, 8));
            @(negedge clk);
            for (int i = 0; i < NR; i++) begin
                chk($sformatf("rnd%0d_p%0d_byp", c, i), rdata_a[i], merged(m_reg[raddr[i]], int'(raddr[i]), 1'b0));
                chk($sformatf("rnd%0d_p%0d_nobyp", c, i), rdata_nb[i], m_reg[raddr[i]]);
                chk($sformatf("rnd%0d_p%0d_zero", c, i), rdata_z[i], merged(m_regz[raddr[i]], int'(raddr[i]), 1'b1));
                chk($sformatf("rnd%0d_p%0d_rbusy", c, i), VL'(rbusy_a[i]), VL'(m_busy[raddr[i]]));
                chk($sformatf("rnd%0d_p%0d_rbusy_z", c, i), VL'(rbusy_z[i]), VL'(m_busyz[raddr[i]]));
            end
            chk($sformatf("rnd%0d_busy", c), VL'(busy_a), VL'(m_busy));
            chk($sformatf("rnd%0d_busy_nb", c), VL'(busy_nb), VL'(m_busy));
            chk($sformatf("rnd%0d_busy_z", c), VL'(busy_z), VL'(m_busyz));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_vregfile
`default_nettype wire
